// File: rtl/aes_io_sequencer.sv
// aes_io_sequencer: moves one AES transaction across an 8-bit bus.
// A command latches the opcode, 32 stream bytes are written to AES addresses
// 0..31, a start pulse is issued, and after completion 16 result bytes are
// read back one at a time and handed out on the result stream.
// Optional feature macro: AES_SEQ_TIMEOUT_EN (bounded wait for IO_DONE with a
// sticky TIMEOUT flag). Without it the wait is unbounded and TIMEOUT is 0.
module aes_io_sequencer #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cmd_go_i,
  input  logic [3:0] cmd_opcode_i,
  input  logic [7:0] s_data_i,
  input  logic       s_valid_i,
  output logic       s_ready_o,
  output logic [7:0] m_data_o,
  output logic       m_valid_o,
  input  logic       m_ready_i,
  output logic [7:0] io_dout_o,
  output logic       io_doe_o,
  input  logic [7:0] io_din_i,
  output logic [4:0] io_addr_o,
  output logic       io_r_w_o,
  output logic [3:0] io_opcode_o,
  output logic       io_start_o,
  input  logic       io_done_i,
  output logic       busy_o,
  output logic       timeout_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_READ  = 3'd4;
  localparam logic [2:0] S_SEND  = 3'd5;

  logic [2:0] state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [3:0] op_q, op_d;
  logic       m_valid_q, m_valid_d;
  logic [7:0] m_data_q, m_data_d;

`ifdef AES_SEQ_TIMEOUT_EN
  // Wide enough to hold TIMEOUT_CYCLES-1 even for tiny settings.
  localparam int WCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);

  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              tmo_q, tmo_d;
`endif

  // Next-state logic: sequencing, byte counter, result capture, timeout.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
`ifdef AES_SEQ_TIMEOUT_EN
    wcnt_d    = wcnt_q;
    tmo_d     = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_go_i) begin
          op_d    = cmd_opcode_i;
          cnt_d   = 5'd0;
          state_d = S_LOAD;
`ifdef AES_SEQ_TIMEOUT_EN
          tmo_d   = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        // Counter wraps 31 -> 0 so the read phase starts at address 0.
        if (s_valid_i) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = S_START;
        end
      end
      S_START: begin
        state_d = S_WAIT;
`ifdef AES_SEQ_TIMEOUT_EN
        wcnt_d  = '0;
`endif
      end
      S_WAIT: begin
        if (io_done_i) begin
          state_d = S_READ;
        end
`ifdef AES_SEQ_TIMEOUT_EN
        else if (wcnt_q == WCNT_LAST) begin
          // Give up without producing any result bytes.
          tmo_d   = 1'b1;
          cnt_d   = 5'd0;
          state_d = S_IDLE;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
`endif
      end
      S_READ: begin
        m_data_d  = io_din_i;
        m_valid_d = 1'b1;
        state_d   = S_SEND;
      end
      S_SEND: begin
        if (m_ready_i) begin
          m_valid_d = 1'b0;
          if (cnt_q == 5'd15) begin
            cnt_d   = 5'd0;
            state_d = S_IDLE;
          end else begin
            cnt_d   = cnt_q + 5'd1;
            state_d = S_READ;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 5'd0;
      end
    endcase
  end

  // State registers; reset returns everything to an idle, bus-released state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      op_q      <= 4'd0;
      m_valid_q <= 1'b0;
      m_data_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

`ifdef AES_SEQ_TIMEOUT_EN
  // Wait-cycle counter and sticky timeout flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wcnt_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      tmo_q  <= tmo_d;
    end
  end

  assign timeout_o = tmo_q;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign timeout_o  = 1'b0;
`endif

  // Bus and handshake decode; the bus is only driven while a byte is offered
  // in LOAD, so AES read data never sees contention.
  always_comb begin
    s_ready_o  = 1'b0;
    io_dout_o  = 8'd0;
    io_doe_o   = 1'b0;
    io_addr_o  = 5'd0;
    io_r_w_o   = 1'b1;
    io_start_o = 1'b0;
    case (state_q)
      S_LOAD: begin
        s_ready_o = 1'b1;
        io_addr_o = cnt_q;
        io_dout_o = s_data_i;
        if (s_valid_i) begin
          io_r_w_o = 1'b0;
          io_doe_o = 1'b1;
        end
      end
      S_START: io_start_o = 1'b1;
      S_READ:  io_addr_o  = {1'b0, cnt_q[3:0]};
      default: ;
    endcase
  end

  assign io_opcode_o = (state_q == S_IDLE) ? 4'd0 : op_q;
  assign busy_o      = (state_q != S_IDLE);
  assign m_valid_o   = m_valid_q;
  assign m_data_o    = m_data_q;

endmodule

// File: tb/tb_aes_io_sequencer.sv
// Scoreboard bench for aes_io_sequencer: stimulus pushes expected bus writes
// and result bytes; a negedge monitor pops and compares them.
module tb_aes_io_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_go;
  logic [3:0] cmd_opcode;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] io_dout;
  logic       io_doe;
  logic [7:0] io_din;
  logic [4:0] io_addr;
  logic       io_r_w;
  logic [3:0] io_opcode;
  logic       io_start;
  logic       io_done;
  logic       busy;
  logic       timeout;

`ifdef AES_SEQ_TIMEOUT_EN
  localparam int DONE_DLY = 8;
`else
  localparam int DONE_DLY = 50;
`endif

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  logic [12:0] wq[$];
  logic [7:0]  rq[$];

  always #5 clk = ~clk;

  // AES read model: returns 0xA0 + address.
  assign io_din = 8'hA0 + {3'b000, io_addr};

  aes_io_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .cmd_go_i(cmd_go), .cmd_opcode_i(cmd_opcode),
    .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .m_data_o(m_data), .m_valid_o(m_valid), .m_ready_i(m_ready),
    .io_dout_o(io_dout), .io_doe_o(io_doe), .io_din_i(io_din),
    .io_addr_o(io_addr), .io_r_w_o(io_r_w), .io_opcode_o(io_opcode),
    .io_start_o(io_start), .io_done_i(io_done), .busy_o(busy),
    .timeout_o(timeout)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Monitor: bus writes, result handshakes, stall stability, start pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!s_valid) chk("doe_no_valid", io_doe, 1'b0);
      chk("doe_vs_rw", io_doe, !io_r_w);
      if (io_doe && !io_r_w) begin
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected addr=%0h data=%0h", io_addr, io_dout);
        end else begin
          logic [12:0] e;
          e = wq.pop_front();
          chk("wr_addr", io_addr, e[12:8]);
          chk("wr_data", io_dout, e[7:0]);
        end
      end
      if (m_valid) begin
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL m_valid_unexpected data=%0h", m_data);
        end else if (m_ready) begin
          chk("m_data", m_data, rq.pop_front());
        end else begin
          chk("m_stall_data", m_data, rq[0]);
        end
      end
      if (io_start) start_cnt++;
    end
  end

  task automatic chk_reset();
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 8'h00);
    chk("rst_io_dout", io_dout, 8'h00);
    chk("rst_io_doe", io_doe, 1'b0);
    chk("rst_io_addr", io_addr, 5'd0);
    chk("rst_io_r_w", io_r_w, 1'b1);
    chk("rst_io_opcode", io_opcode, 4'd0);
    chk("rst_io_start", io_start, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
  endtask

  task automatic go(input logic [3:0] op);
    cmd_go = 1'b1; cmd_opcode = op;
    @(posedge clk); #1;
    cmd_go = 1'b0; cmd_opcode = 4'hF;
  endtask

  // Offer n bytes base+i; optional idle gap after each byte and a stray
  // IO_DONE pulse alongside byte 3.
  task automatic feed(input int n, input logic [7:0] base, input bit tog, input bit spd);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      logic [7:0] d;
      logic [4:0] a;
      d = base + 8'(i);
      a = 5'(i);
      wq.push_back({a, d});
      s_data = d; s_valid = 1'b1; io_done = spd && (i == 3);
      @(negedge clk);
      while (!s_ready && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) begin errors++; $display("FAIL s_ready_timeout byte=%0d", i); end
      @(posedge clk); #1;
      io_done = 1'b0;
      if (tog) begin s_valid = 1'b0; @(posedge clk); #1; end
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 500) begin @(negedge clk); t++; end
    if (t >= 500) begin errors++; $display("FAIL busy_timeout got=1 exp=0"); end
  endtask

  task automatic txn(input logic [3:0] op, input logic [7:0] base, input bit tog,
                     input bit stall, input bit spd, input bit spgo);
    int sc0;
    sc0 = start_cnt;
    for (int i = 0; i < 16; i++) rq.push_back(8'hA0 + 8'(i));
    m_ready = !stall;
    go(op);
    feed(32, base, tog, spd);
    for (int k = 0; k < DONE_DLY; k++) begin
      cmd_go = spgo && (k == 5);
      cmd_opcode = 4'h9;
      @(posedge clk); #1;
    end
    cmd_go = 1'b0;
    chk("wait_opcode", io_opcode, op);
    chk("wait_busy", busy, 1'b1);
    chk("wait_no_mvalid", m_valid, 1'b0);
    io_done = 1'b1;
    @(posedge clk); #1;
    io_done = 1'b0;
    if (stall) begin
      for (int i = 0; i < 16; i++) begin
        int t = 0;
        @(negedge clk);
        while (!m_valid && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) begin errors++; $display("FAIL m_valid_timeout byte=%0d", i); end
        repeat (5) @(negedge clk);
        @(posedge clk); #1; m_ready = 1'b1;
        @(posedge clk); #1; m_ready = 1'b0;
      end
    end
    wait_idle();
    chk("end_busy", busy, 1'b0);
    chk("end_rq_empty", rq.size(), 0);
    chk("end_wq_empty", wq.size(), 0);
    chk("end_start_pulses", start_cnt - sc0, 1);
    chk("end_opcode", io_opcode, 4'd0);
    chk("end_timeout", timeout, 1'b0);
    chk("end_s_ready", s_ready, 1'b0);
    m_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; cmd_go = 1'b0; cmd_opcode = 4'd0; s_data = 8'd0;
    s_valid = 1'b0; m_ready = 1'b0; io_done = 1'b0;
    #3 chk_reset();
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    // Straight transaction, bytes 0x00..0x1F.
    txn(4'b0010, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    // Gapped input stream, stalled result stream.
    txn(4'b1101, 8'h40, 1'b1, 1'b1, 1'b0, 1'b0);
    // Stray IO_DONE in LOAD and CMD_GO in WAIT.
    txn(4'b0111, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1);

    // Reset at CNT=20 while a byte is being offered.
    go(4'b1010);
    feed(20, 8'h20, 1'b0, 1'b0);
    s_data = 8'h55; s_valid = 1'b1;
    rst_n = 1'b0;
    #1 chk_reset();
    s_valid = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    txn(4'b0100, 8'hC0, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef AES_SEQ_TIMEOUT_EN
    begin
      int n = 0;
      go(4'b0001);
      feed(32, 8'h10, 1'b0, 1'b0);
      @(negedge clk);
      chk("tmo_start", io_start, 1'b1);
      do begin @(negedge clk); n++; end while (busy && n < 100);
      chk("tmo_cycles", n, 17);
      chk("tmo_flag", timeout, 1'b1);
      chk("tmo_no_mvalid", m_valid, 1'b0);
      @(posedge clk); #1;
      chk("tmo_sticky", timeout, 1'b1);
      go(4'b0011);
      chk("tmo_cleared", timeout, 1'b0);
      chk("tmo_busy_again", busy, 1'b1);
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_io_sequencer.md
AES_IO_SEQUENCER -- requirements
Module: aes_io_sequencer

Interface
REQ-001 TIMEOUT_CYCLES, 4096, maximum cycles spent waiting for IO_DONE (used only when AES_SEQ_TIMEOUT_EN is defined).
REQ-002 CLOCK  in  1  system clock, rising edge.
REQ-003 RESET  in  1  asynchronous, active-low reset.
REQ-004 CMD_GO  in  1  one-cycle request to start one AES transaction.
REQ-005 CMD_OPCODE  in  4  {MODE[1:0], E_D, D_K}; latched on the accepted CMD_GO.
REQ-006 S_DATA  in  8  input byte stream (data/key bytes, byte 0 first).
REQ-007 S_VALID / S_READY  in / out  1 each  input stream handshake.
REQ-008 M_DATA  out  8  result byte stream (result byte 0 first).
REQ-009 M_VALID / M_READY  out / in  1 each  result stream handshake.
REQ-010 IO_DOUT  out  8  byte driven onto the AES 8-bit data bus.
REQ-011 IO_DOE  out  1  bus output enable: 1 = sequencer drives the bus.
REQ-012 IO_DIN  in  8  byte read from the AES data bus.
REQ-013 IO_ADDR  out  5  AES byte address.
REQ-014 IO_R_W  out  1  0 = write, 1 = read.
REQ-015 IO_OPCODE  out  4  opcode presented to the AES block.
REQ-016 IO_START  out  1  AES start pulse.
REQ-017 IO_DONE  in  1  AES completion.
REQ-018 BUSY  out  1  high whenever the state is not IDLE.
REQ-019 TIMEOUT  out  1  sticky error flag; constant 0 when AES_SEQ_TIMEOUT_EN is undefined.

Function
REQ-020 The FSM SHALL have the states IDLE, LOAD, START, WAIT, READ and SEND, plus a 5-bit byte counter CNT.
REQ-021 IDLE: S_READY=0. CMD_GO=1 SHALL latch CMD_OPCODE, clear TIMEOUT, set CNT=0 and enter LOAD on the next edge.
REQ-022 In every other state, CMD_GO SHALL be ignored; in IDLE, S_VALID SHALL be ignored.
REQ-023 LOAD: S_READY=1, IO_ADDR=CNT, and IO_DOUT=S_DATA combinationally.
REQ-024 In LOAD, IO_R_W=0 and IO_DOE=1 SHALL hold only in cycles with S_VALID=1; otherwise IO_R_W=1 and IO_DOE=0.
REQ-025 Each accepted byte SHALL increment CNT. Acceptance at CNT=31 SHALL enter START with CNT=0 (wrap).
REQ-026 START: IO_START=1 for exactly one cycle, then the FSM SHALL enter WAIT.
REQ-027 WAIT: the FSM SHALL stay until IO_DONE=1 is sampled, then enter READ; IO_DONE outside WAIT SHALL be ignored.
REQ-028 READ (one cycle): IO_ADDR={1'b0,CNT[3:0]} and IO_R_W=1; IO_DIN SHALL be registered into M_DATA, M_VALID set to 1, and the FSM SHALL enter SEND.
REQ-029 SEND: M_VALID and M_DATA SHALL hold stable until M_READY=1.
REQ-030 On the SEND handshake, M_VALID SHALL clear and CNT SHALL increment; the FSM SHALL return to READ, or to IDLE if CNT was 15.
REQ-031 Throughput: 1 byte/cycle in LOAD; at most 1 result byte per 2 cycles.
REQ-032 IO_OPCODE SHALL equal the latched opcode from LOAD through SEND, and 0 in IDLE.
REQ-033 Outside LOAD: IO_DOE=0 and IO_R_W=1, so the sequencer never contends with AES read data.

Reset
REQ-034 RESET=0 SHALL act immediately, at any point including mid-transaction, forcing IDLE and CNT=0.
REQ-035 RESET=0 SHALL force S_READY=0, M_VALID=0, M_DATA=0, IO_DOUT=0, IO_DOE=0, IO_ADDR=0, IO_R_W=1, IO_OPCODE=0, IO_START=0, BUSY=0 and TIMEOUT=0.

Configuration
REQ-036 With AES_SEQ_TIMEOUT_EN defined: a WAIT-cycle counter SHALL start at 0 on WAIT entry.
REQ-037 With AES_SEQ_TIMEOUT_EN defined: reaching TIMEOUT_CYCLES without IO_DONE SHALL set TIMEOUT=1 and return the FSM to IDLE without emitting any result bytes.
REQ-038 With AES_SEQ_TIMEOUT_EN defined: TIMEOUT SHALL stay set until the next accepted CMD_GO or reset.
REQ-039 With AES_SEQ_TIMEOUT_EN undefined: there SHALL be no WAIT counter, WAIT SHALL wait indefinitely, and TIMEOUT SHALL be tied to 0.

Verification
REQ-040 CMD_GO with opcode 4'b0010, then 32 back-to-back bytes 0x00..0x1F -> IO_R_W=0 at IO_ADDR 0..31 carrying 0x00..0x1F, then exactly one IO_START pulse.
REQ-041 IO_DONE after 50 cycles; model returns 0xA0+addr; M_READY=1 -> M_DATA 0xA0..0xAF in order, then BUSY=0.
REQ-042 S_VALID toggled every other cycle and M_READY held low 5 cycles per byte -> no lost or duplicated bytes, and M_DATA stable while stalled.
REQ-043 Spurious IO_DONE during LOAD and CMD_GO during WAIT -> both ignored; the transaction completes normally.
REQ-044 RESET low at CNT=20 in LOAD -> all REQ-035 values immediately; a following full transaction succeeds.
REQ-045 AES_SEQ_TIMEOUT_EN defined with TIMEOUT_CYCLES=16 and IO_DONE never asserted -> TIMEOUT=1 after 16 WAIT cycles, IDLE, no M_VALID; the next CMD_GO clears TIMEOUT.
